// File: rtl/fp_req_master_if.sv
// Operand/result handshake bundle between the request master and its environment.
// master = the request block, slave = loader/FPU/consumer side.
interface fp_req_master_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             ld_valid_i;
  logic             ld_ready_o;
  logic [WIDTH-1:0] ld_a_i;
  logic [WIDTH-1:0] ld_b_i;
  logic [WIDTH-1:0] ld_c_i;
  logic             req_valid_o;
  logic             req_ready_i;
  logic [WIDTH-1:0] req_a_o;
  logic [WIDTH-1:0] req_b_o;
  logic [WIDTH-1:0] req_c_o;
  logic             rsp_valid_i;
  logic             rsp_ready_o;
  logic [WIDTH-1:0] rsp_data_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [WIDTH-1:0] res_data_o;
  logic [7:0]       outstanding_o;
  logic [CNT_W-1:0] issue_cnt_o;
  logic [CNT_W-1:0] done_cnt_o;
  logic             err_unexp_o;
  logic             busy_o;

  modport master (
    input  ld_valid_i, ld_a_i, ld_b_i, ld_c_i,
    output ld_ready_o,
    output req_valid_o, req_a_o, req_b_o, req_c_o,
    input  req_ready_i,
    input  rsp_valid_i, rsp_data_i,
    output rsp_ready_o,
    output res_valid_o, res_data_o,
    input  res_ready_i,
    output outstanding_o, issue_cnt_o, done_cnt_o,
    output err_unexp_o, busy_o
  );

  modport slave (
    output ld_valid_i, ld_a_i, ld_b_i, ld_c_i,
    input  ld_ready_o,
    input  req_valid_o, req_a_o, req_b_o, req_c_o,
    output req_ready_i,
    output rsp_valid_i, rsp_data_i,
    input  rsp_ready_o,
    input  res_valid_o, res_data_o,
    output res_ready_i,
    input  outstanding_o, issue_cnt_o, done_cnt_o,
    input  err_unexp_o, busy_o
  );
endinterface

// File: rtl/fp_req_master.sv
// FPU request master: operand FIFO, in-order issue with an outstanding cap,
// one-entry result register, issue/done counters and unexpected-response flag.
module fp_req_master #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 16
) (
  input logic clk_i,
  input logic rst_ni,
  fp_req_master_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = 3 * WIDTH;
  localparam logic [7:0] MAX_O = 8'(MAX_OUT);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);

  logic [TW-1:0]    mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic [TW-1:0]    head;
  logic [7:0]       outs;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             err;
  logic             push;
  logic             pop;
  logic             req_valid;
  logic             rsp_ready;
  logic             rsp_fire;
  logic             rsp_ok;

  assign count = wptr - rptr;
  assign full  = (count == FULL_N);
  assign empty = (wptr == rptr);
  assign head  = mem[rptr[AW-1:0]];

  assign req_valid = !empty && (outs < MAX_O);
  assign push      = bus.ld_valid_i && !full;
  assign pop       = req_valid && bus.req_ready_i;
  assign rsp_ready = !res_valid || bus.res_ready_i;
  assign rsp_fire  = bus.rsp_valid_i && rsp_ready;
  // A response is expected if something is in flight or issuing right now.
  assign rsp_ok    = rsp_fire && ((outs != 8'd0) || pop);

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[AW-1:0]] <= {bus.ld_a_i, bus.ld_b_i, bus.ld_c_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr      <= '0;
      rptr      <= '0;
      outs      <= '0;
      issue_cnt <= '0;
      done_cnt  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr      <= rptr + 1'b1;
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      outs <= outs + {7'd0, pop} - {7'd0, rsp_ok};
      if (rsp_ok) begin
        res_data  <= bus.rsp_data_i;
        res_valid <= 1'b1;
        done_cnt  <= done_cnt + CNT_W'(1);
      end else if (bus.res_ready_i) begin
        res_valid <= 1'b0;
      end
      if (rsp_fire && !rsp_ok) err <= 1'b1;
    end
  end

  assign bus.ld_ready_o    = !full;
  assign bus.req_valid_o   = req_valid;
  assign bus.req_a_o       = head[TW-1 -: WIDTH];
  assign bus.req_b_o       = head[2*WIDTH-1 -: WIDTH];
  assign bus.req_c_o       = head[WIDTH-1:0];
  assign bus.rsp_ready_o   = rsp_ready;
  assign bus.res_valid_o   = res_valid;
  assign bus.res_data_o    = res_data;
  assign bus.outstanding_o = outs;
  assign bus.issue_cnt_o   = issue_cnt;
  assign bus.done_cnt_o    = done_cnt;
  assign bus.err_unexp_o   = err;
  assign bus.busy_o        = !empty || (outs != 8'd0) || res_valid;
endmodule

// File: tb/tb_fp_req_master.sv
// Bench for fp_req_master: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_fp_req_master;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int MO = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_req_master_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  fp_req_master #(
    .WIDTH(W), .DEPTH(D), .MAX_OUT(MO), .CNT_W(CW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int failures = 0;

  logic [47:0] q[$];
  int          m_outs;
  logic [15:0] m_iss;
  logic [15:0] m_done;
  bit          m_rv;
  logic [15:0] m_rd;
  bit          m_err;

  typedef struct {
    bit          ldv;
    logic [15:0] a, b, c;
    bit          reqr, rspv;
    logic [15:0] rspd;
    bit          resr;
    bit          e_ldr, e_reqv;
    logic [15:0] e_reqa;
    bit          e_rspr;
    int          e_outs;
    bit          e_resv;
    logic [15:0] e_resd;
    int          e_iss, e_done;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_outs = 0;
    m_iss = '0;
    m_done = '0;
    m_rv = 1'b0;
    m_rd = '0;
    m_err = 1'b0;
  endtask

  function automatic bit m_reqv();
    return (q.size() > 0) && (m_outs < MO);
  endfunction

  task automatic compare_model();
    bit rv;
    rv = m_reqv();
    chk("m_ld_ready", 32'(bus.ld_ready_o), 32'(q.size() < D));
    chk("m_req_valid", 32'(bus.req_valid_o), 32'(rv));
    if (rv) begin
      chk("m_req_a", 32'(bus.req_a_o), 32'(q[0][47:32]));
      chk("m_req_b", 32'(bus.req_b_o), 32'(q[0][31:16]));
      chk("m_req_c", 32'(bus.req_c_o), 32'(q[0][15:0]));
    end
    chk("m_rsp_ready", 32'(bus.rsp_ready_o), 32'(!m_rv || bus.res_ready_i));
    chk("m_res_valid", 32'(bus.res_valid_o), 32'(m_rv));
    chk("m_res_data", 32'(bus.res_data_o), 32'(m_rd));
    chk("m_outstanding", 32'(bus.outstanding_o), 32'(m_outs));
    chk("m_issue_cnt", 32'(bus.issue_cnt_o), 32'(m_iss));
    chk("m_done_cnt", 32'(bus.done_cnt_o), 32'(m_done));
    chk("m_err", 32'(bus.err_unexp_o), 32'(m_err));
    chk("m_busy", 32'(bus.busy_o),
        32'((q.size() > 0) || (m_outs != 0) || m_rv));
  endtask

  task automatic model_step();
    bit ldr, rv, pop, push, fire, ok;
    ldr  = q.size() < D;
    rv   = m_reqv();
    push = bus.ld_valid_i && ldr;
    pop  = rv && bus.req_ready_i;
    fire = bus.rsp_valid_i && (!m_rv || bus.res_ready_i);
    ok   = fire && (m_outs > 0 || pop);
    if (pop) begin
      void'(q.pop_front());
      m_iss = m_iss + 16'd1;
    end
    if (push) q.push_back({bus.ld_a_i, bus.ld_b_i, bus.ld_c_i});
    m_outs = m_outs + int'(pop) - int'(ok);
    if (ok) begin
      m_rd = bus.rsp_data_i;
      m_rv = 1'b1;
      m_done = m_done + 16'd1;
    end else if (bus.res_ready_i) begin
      m_rv = 1'b0;
    end
    if (fire && !ok) m_err = 1'b1;
  endtask

  task automatic tick_pre();
    @(negedge clk);
  endtask

  task automatic tick_post();
    compare_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_pre();
    tick_post();
  endtask

  task automatic idle_in();
    bus.ld_valid_i  = 1'b0;
    bus.req_ready_i = 1'b0;
    bus.rsp_valid_i = 1'b0;
    bus.res_ready_i = 1'b1;
  endtask

  task automatic load(logic [15:0] a, logic [15:0] b, logic [15:0] c);
    bus.ld_valid_i = 1'b1;
    bus.ld_a_i = a;
    bus.ld_b_i = b;
    bus.ld_c_i = c;
  endtask

  task automatic drain();
    idle_in();
    bus.req_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.rsp_valid_i = (m_outs > 0);
      bus.rsp_data_i = 16'($urandom);
      tick();
    end
    idle_in();
    tick();
    chk("drain_idle", 32'(bus.busy_o), 32'(0));
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_ld_ready"}, 32'(bus.ld_ready_o), 32'(1));
    chk({tag, "_req_valid"}, 32'(bus.req_valid_o), 32'(0));
    chk({tag, "_rsp_ready"}, 32'(bus.rsp_ready_o), 32'(1));
    chk({tag, "_res_valid"}, 32'(bus.res_valid_o), 32'(0));
    chk({tag, "_res_data"}, 32'(bus.res_data_o), 32'(0));
    chk({tag, "_outs"}, 32'(bus.outstanding_o), 32'(0));
    chk({tag, "_issue"}, 32'(bus.issue_cnt_o), 32'(0));
    chk({tag, "_done"}, 32'(bus.done_cnt_o), 32'(0));
    chk({tag, "_err"}, 32'(bus.err_unexp_o), 32'(0));
  endtask

  task automatic rand_in();
    bus.ld_valid_i  = 1'($urandom);
    bus.ld_a_i      = 16'($urandom);
    bus.ld_b_i      = 16'($urandom);
    bus.ld_c_i      = 16'($urandom);
    bus.req_ready_i = 1'($urandom);
    bus.rsp_valid_i = 1'($urandom);
    bus.rsp_data_i  = 16'($urandom);
    bus.res_ready_i = 1'($urandom);
  endtask

  initial begin
    logic [15:0] base;
    model_reset();
    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      rand_in();
      #3;
      check_reset_vals("rst");
      @(posedge clk);
      #1;
    end
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single op, cycle by cycle
    //         ldv a        b        c     rr rv rspd     rr  ldr rqv reqa     rspr o rv resd     is dn
    tbl[0] = '{1, 16'h3C00, 16'h4000, 16'h0, 1, 0, 16'h0,    1, 1, 0, 16'h0,    1, 0, 0, 16'h0,    0, 0};
    tbl[1] = '{0, 16'h0,    16'h0,    16'h0, 1, 0, 16'h0,    1, 1, 1, 16'h3C00, 1, 0, 0, 16'h0,    0, 0};
    tbl[2] = '{0, 16'h0,    16'h0,    16'h0, 1, 0, 16'h0,    1, 1, 0, 16'h0,    1, 1, 0, 16'h0,    1, 0};
    tbl[3] = '{0, 16'h0,    16'h0,    16'h0, 1, 1, 16'h4000, 1, 1, 0, 16'h0,    1, 1, 0, 16'h0,    1, 0};
    tbl[4] = '{0, 16'h0,    16'h0,    16'h0, 1, 0, 16'h0,    0, 1, 0, 16'h0,    0, 0, 1, 16'h4000, 1, 1};
    tbl[5] = '{0, 16'h0,    16'h0,    16'h0, 1, 0, 16'h0,    1, 1, 0, 16'h0,    1, 0, 1, 16'h4000, 1, 1};
    tbl[6] = '{0, 16'h0,    16'h0,    16'h0, 1, 0, 16'h0,    1, 1, 0, 16'h0,    1, 0, 0, 16'h4000, 1, 1};
    for (int i = 0; i < 7; i++) begin
      bus.ld_valid_i  = tbl[i].ldv;
      bus.ld_a_i      = tbl[i].a;
      bus.ld_b_i      = tbl[i].b;
      bus.ld_c_i      = tbl[i].c;
      bus.req_ready_i = tbl[i].reqr;
      bus.rsp_valid_i = tbl[i].rspv;
      bus.rsp_data_i  = tbl[i].rspd;
      bus.res_ready_i = tbl[i].resr;
      tick_pre();
      chk($sformatf("v%0d_ld_ready", i), 32'(bus.ld_ready_o), 32'(tbl[i].e_ldr));
      chk($sformatf("v%0d_req_valid", i), 32'(bus.req_valid_o), 32'(tbl[i].e_reqv));
      if (tbl[i].e_reqv)
        chk($sformatf("v%0d_req_a", i), 32'(bus.req_a_o), 32'(tbl[i].e_reqa));
      chk($sformatf("v%0d_rsp_ready", i), 32'(bus.rsp_ready_o), 32'(tbl[i].e_rspr));
      chk($sformatf("v%0d_outs", i), 32'(bus.outstanding_o), 32'(tbl[i].e_outs));
      chk($sformatf("v%0d_res_valid", i), 32'(bus.res_valid_o), 32'(tbl[i].e_resv));
      chk($sformatf("v%0d_res_data", i), 32'(bus.res_data_o), 32'(tbl[i].e_resd));
      chk($sformatf("v%0d_issue", i), 32'(bus.issue_cnt_o), 32'(tbl[i].e_iss));
      chk($sformatf("v%0d_done", i), 32'(bus.done_cnt_o), 32'(tbl[i].e_done));
      tick_post();
    end

    // request backpressure: held stable for 5 cycles
    idle_in();
    load(16'h1111, 16'h2222, 16'h3333);
    tick();
    bus.ld_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_pre();
      chk("bp_req_valid", 32'(bus.req_valid_o), 32'(1));
      chk("bp_req_a", 32'(bus.req_a_o), 32'h1111);
      chk("bp_req_b", 32'(bus.req_b_o), 32'h2222);
      chk("bp_req_c", 32'(bus.req_c_o), 32'h3333);
      tick_post();
    end
    bus.req_ready_i = 1'b1;
    tick();
    bus.req_ready_i = 1'b0;
    tick_pre();
    chk("bp_one_issue", 32'(bus.issue_cnt_o), 32'(2));
    chk("bp_req_gone", 32'(bus.req_valid_o), 32'(0));
    tick_post();
    drain();

    // FIFO full: 5th triple refused until the first issue
    idle_in();
    for (int i = 0; i < 5; i++) begin
      load(16'(16'h0A00 + i), 16'(16'h0B00 + i), 16'(16'h0C00 + i));
      tick_pre();
      chk("full_ld_ready", 32'(bus.ld_ready_o), 32'(i < 4));
      tick_post();
    end
    tick_pre();
    chk("full_held", 32'(bus.ld_ready_o), 32'(0));
    tick_post();
    bus.req_ready_i = 1'b1;
    tick_pre();
    chk("full_no_bypass", 32'(bus.ld_ready_o), 32'(0));
    tick_post();
    bus.req_ready_i = 1'b0;
    tick_pre();
    chk("full_reopen", 32'(bus.ld_ready_o), 32'(1));
    tick_post();
    bus.ld_valid_i = 1'b0;
    tick_pre();
    chk("full_fifth_in", 32'(bus.ld_ready_o), 32'(0));
    chk("full_head", 32'(bus.req_a_o), 32'h0A01);
    tick_post();
    drain();

    // outstanding cap
    idle_in();
    base = bus.issue_cnt_o;
    bus.req_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load(16'(16'h5000 + i), 16'(i), 16'(i));
      tick();
    end
    bus.ld_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tick_pre();
    chk("cap_outs", 32'(bus.outstanding_o), 32'(MO));
    chk("cap_req_valid", 32'(bus.req_valid_o), 32'(0));
    chk("cap_issued", 32'(bus.issue_cnt_o - base), 32'(4));
    tick_post();
    bus.rsp_valid_i = 1'b1;
    bus.rsp_data_i = 16'hBEEF;
    tick();
    bus.rsp_valid_i = 1'b0;
    tick();
    tick_pre();
    chk("cap_one_more", 32'(bus.issue_cnt_o - base), 32'(5));
    chk("cap_outs2", 32'(bus.outstanding_o), 32'(MO));
    tick_post();
    drain();

    // result backpressure and unexpected response
    idle_in();
    load(16'h1, 16'h2, 16'h3);
    bus.req_ready_i = 1'b1;
    tick();
    bus.ld_valid_i = 1'b0;
    tick();
    bus.res_ready_i = 1'b0;
    bus.rsp_valid_i = 1'b1;
    bus.rsp_data_i = 16'h7777;
    tick();
    bus.rsp_valid_i = 1'b0;
    tick_pre();
    chk("rb_res_valid", 32'(bus.res_valid_o), 32'(1));
    chk("rb_rsp_ready", 32'(bus.rsp_ready_o), 32'(0));
    tick_post();
    base = bus.done_cnt_o;
    bus.res_ready_i = 1'b1;
    bus.rsp_valid_i = 1'b1;
    bus.rsp_data_i = 16'h9999;
    tick();
    bus.rsp_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_pre();
      chk("ux_err", 32'(bus.err_unexp_o), 32'(1));
      chk("ux_done", 32'(bus.done_cnt_o), 32'(base));
      chk("ux_data", 32'(bus.res_data_o), 32'h7777);
      tick_post();
    end

    // reset in the middle of traffic
    for (int i = 0; i < 6; i++) begin
      rand_in();
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    model_reset();
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      if (m_outs == 0) bus.rsp_valid_i = ($urandom_range(0, 49) == 0);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
